// File: rtl/alu_control_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | alu_control_seq                                                          |
// | Registered ALU control decoder with iterative multiply/divide sequencing |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module alu_control_seq #(
    parameter int DATA_W = 32,
    parameter int FUNC_W = 6,
    parameter int CTRL_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sig_valid_in,
    input  logic [1:0]        sig_ALUop,
    input  logic [FUNC_W-1:0] func,
    output logic              sig_ready_out,
    output logic              sig_stall,
    output logic [CTRL_W-1:0] sig_alu_control,
    output logic              sig_valid_out,
    output logic              sig_md_step,
    output logic              sig_md_last,
    output logic              sig_illegal
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(DATA_W - 1);

    localparam logic [CTRL_W-1:0] c_add = CTRL_W'(0);
    localparam logic [CTRL_W-1:0] c_sub = CTRL_W'(1);
    localparam logic [CTRL_W-1:0] c_and = CTRL_W'(2);
    localparam logic [CTRL_W-1:0] c_or  = CTRL_W'(3);
    localparam logic [CTRL_W-1:0] c_slt = CTRL_W'(4);
    localparam logic [CTRL_W-1:0] c_xor = CTRL_W'(5);
    localparam logic [CTRL_W-1:0] c_nor = CTRL_W'(6);
    localparam logic [CTRL_W-1:0] c_sll = CTRL_W'(7);
    localparam logic [CTRL_W-1:0] c_srl = CTRL_W'(8);
    localparam logic [CTRL_W-1:0] c_mul = CTRL_W'(9);
    localparam logic [CTRL_W-1:0] c_div = CTRL_W'(10);
    localparam logic [CTRL_W-1:0] c_nop = CTRL_W'(15);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [CTRL_W-1:0] md_code_q, md_code_d;
    logic [CTRL_W-1:0] alu_control_q, alu_control_d;
    logic              valid_q, valid_d;
    logic              md_step_q, md_step_d;
    logic              md_last_q, md_last_d;
    logic              illegal_q, illegal_d;

    logic              w_func_hi_zero;
    logic [CTRL_W-1:0] w_dec_code;
    logic              w_dec_md;
    logic              w_dec_illegal;
    logic              w_last;
    logic              w_accept;
    logic [CNT_W-1:0]  w_count_inc;

    // Function bits above the architected 6 must be zero for a legal op.
    if (FUNC_W > 6) begin : g_func_hi
        assign w_func_hi_zero = ~|func[FUNC_W-1:6];
    end else begin : g_func_exact
        assign w_func_hi_zero = 1'b1;
    end

    always_comb begin
        w_dec_code    = c_nop;
        w_dec_md      = 1'b0;
        w_dec_illegal = 1'b0;
        case (sig_ALUop)
            2'b11: w_dec_code = c_add;
            2'b10: w_dec_code = c_sub;
            2'b01: w_dec_code = c_and;
            default: begin
                if (!w_func_hi_zero) begin
                    w_dec_illegal = 1'b1;
                end else begin
                    case (func[5:0])
                        6'h00: w_dec_code = c_or;
                        6'h01: w_dec_code = c_add;
                        6'h02: w_dec_code = c_sub;
                        6'h03: w_dec_code = c_and;
                        6'h04: w_dec_code = c_slt;
                        6'h05: w_dec_code = c_xor;
                        6'h06: w_dec_code = c_nor;
                        6'h07: w_dec_code = c_sll;
                        6'h08: w_dec_code = c_srl;
                        6'h18: begin w_dec_code = c_mul; w_dec_md = 1'b1; end
                        6'h1A: begin w_dec_code = c_div; w_dec_md = 1'b1; end
                        default: w_dec_illegal = 1'b1;
                    endcase
                end
            end
        endcase
    end

    assign w_last        = (count_q == c_last_cnt);
    assign w_count_inc   = count_q + CNT_W'(1);
    assign sig_ready_out = rst_n & ((state_q == S_IDLE) | w_last);
    assign sig_stall     = ~sig_ready_out;
    assign w_accept      = sig_valid_in & sig_ready_out;

    always_comb begin
        state_d       = S_IDLE;
        count_d       = '0;
        md_code_d     = md_code_q;
        alu_control_d = c_nop;
        valid_d       = 1'b0;
        md_step_d     = 1'b0;
        md_last_d     = 1'b0;
        illegal_d     = 1'b0;
        if ((state_q == S_RUN) && !w_last) begin
            state_d       = S_RUN;
            count_d       = w_count_inc;
            alu_control_d = md_code_q;
            md_step_d     = 1'b1;
            md_last_d     = (w_count_inc == c_last_cnt);
            valid_d       = (w_count_inc == c_last_cnt);
        end else if (w_accept) begin
            // The final MD cycle accepts exactly like IDLE, so MD ops chain.
            if (w_dec_md) begin
                state_d       = S_RUN;
                md_code_d     = w_dec_code;
                alu_control_d = w_dec_code;
                md_step_d     = 1'b1;
            end else begin
                alu_control_d = w_dec_code;
                valid_d       = 1'b1;
                illegal_d     = w_dec_illegal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            md_code_q     <= c_nop;
            alu_control_q <= c_nop;
            valid_q       <= 1'b0;
            md_step_q     <= 1'b0;
            md_last_q     <= 1'b0;
            illegal_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            md_code_q     <= md_code_d;
            alu_control_q <= alu_control_d;
            valid_q       <= valid_d;
            md_step_q     <= md_step_d;
            md_last_q     <= md_last_d;
            illegal_q     <= illegal_d;
        end
    end

    assign sig_alu_control = alu_control_q;
    assign sig_valid_out   = valid_q;
    assign sig_md_step     = md_step_q;
    assign sig_md_last     = md_last_q;
    assign sig_illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_alu_control_seq                                                       |
// | Table-driven bench with an expected-output queue, DATA_W=4, FUNC_W=8     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_alu_control_seq;

    localparam int DATA_W = 4;
    localparam int FUNC_W = 8;
    localparam int CTRL_W = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sig_valid_in = 1'b0;
    logic [1:0]        sig_ALUop = 2'b00;
    logic [FUNC_W-1:0] func = '0;
    logic              sig_ready_out;
    logic              sig_stall;
    logic [CTRL_W-1:0] sig_alu_control;
    logic              sig_valid_out;
    logic              sig_md_step;
    logic              sig_md_last;
    logic              sig_illegal;

    alu_control_seq #(
        .DATA_W(DATA_W),
        .FUNC_W(FUNC_W),
        .CTRL_W(CTRL_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sig_valid_in   (sig_valid_in),
        .sig_ALUop      (sig_ALUop),
        .func           (func),
        .sig_ready_out  (sig_ready_out),
        .sig_stall      (sig_stall),
        .sig_alu_control(sig_alu_control),
        .sig_valid_out  (sig_valid_out),
        .sig_md_step    (sig_md_step),
        .sig_md_last    (sig_md_last),
        .sig_illegal    (sig_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [1:0] op;
        logic [7:0] func;
        logic       rdy;
        logic [3:0] ctrl;
        logic       vld;
        logic       stp;
        logic       lst;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [3:0] ctrl;
        logic       vld;
        logic       stp;
        logic       lst;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_pop;
    int   tests = 0;
    int   fails = 0;

    localparam int N_DEC = 18;
    vec_t tbl[N_DEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(input logic r, input logic v, input logic [1:0] op,
                                input logic [7:0] f, input logic rdy, input logic [3:0] c,
                                input logic vl, input logic st, input logic ls, input logic il);
        vec_t t;
        t.rst_n = r; t.valid = v; t.op = op; t.func = f; t.rdy = rdy;
        t.ctrl = c; t.vld = vl; t.stp = st; t.lst = ls; t.ill = il;
        return t;
    endfunction

    // Drive one cycle of stimulus, check ready/stall now, queue next-cycle outputs.
    task automatic apply(input vec_t v);
        exp_t e;
        @(negedge clk);
        rst_n        = v.rst_n;
        sig_valid_in = v.valid;
        sig_ALUop    = v.op;
        func         = v.func;
        #1;
        chk("ready", {31'd0, sig_ready_out}, {31'd0, v.rdy});
        chk("stall", {31'd0, sig_stall}, {31'd0, ~v.rdy});
        e.ctrl = v.ctrl; e.vld = v.vld; e.stp = v.stp; e.lst = v.lst; e.ill = v.ill;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            e_pop = exp_q.pop_front();
            chk("alu_control", {28'd0, sig_alu_control}, {28'd0, e_pop.ctrl});
            chk("valid_out",   {31'd0, sig_valid_out},   {31'd0, e_pop.vld});
            chk("md_step",     {31'd0, sig_md_step},     {31'd0, e_pop.stp});
            chk("md_last",     {31'd0, sig_md_last},     {31'd0, e_pop.lst});
            chk("illegal",     {31'd0, sig_illegal},     {31'd0, e_pop.ill});
        end
    end

    initial begin
        //           rst v  op     func   rdy ctrl vld stp lst ill
        tbl[0]  = mk(1, 1, 2'b00, 8'h00, 1, 4'd3,  1, 0, 0, 0);
        tbl[1]  = mk(1, 1, 2'b00, 8'h01, 1, 4'd0,  1, 0, 0, 0);
        tbl[2]  = mk(1, 1, 2'b00, 8'h02, 1, 4'd1,  1, 0, 0, 0);
        tbl[3]  = mk(1, 1, 2'b00, 8'h03, 1, 4'd2,  1, 0, 0, 0);
        tbl[4]  = mk(1, 1, 2'b00, 8'h04, 1, 4'd4,  1, 0, 0, 0);
        tbl[5]  = mk(1, 1, 2'b11, 8'h04, 1, 4'd0,  1, 0, 0, 0);
        tbl[6]  = mk(1, 0, 2'b00, 8'h04, 1, 4'hF,  0, 0, 0, 0);
        tbl[7]  = mk(1, 1, 2'b00, 8'h05, 1, 4'd5,  1, 0, 0, 0);
        tbl[8]  = mk(1, 1, 2'b00, 8'h06, 1, 4'd6,  1, 0, 0, 0);
        tbl[9]  = mk(1, 1, 2'b00, 8'h07, 1, 4'd7,  1, 0, 0, 0);
        tbl[10] = mk(1, 1, 2'b00, 8'h08, 1, 4'd8,  1, 0, 0, 0);
        tbl[11] = mk(1, 1, 2'b01, 8'hFF, 1, 4'd2,  1, 0, 0, 0);
        tbl[12] = mk(1, 1, 2'b10, 8'h18, 1, 4'd1,  1, 0, 0, 0);
        tbl[13] = mk(1, 1, 2'b00, 8'h3F, 1, 4'hF,  1, 0, 0, 1);
        tbl[14] = mk(1, 1, 2'b00, 8'h09, 1, 4'hF,  1, 0, 0, 1);
        tbl[15] = mk(1, 1, 2'b00, 8'h44, 1, 4'hF,  1, 0, 0, 1);
        tbl[16] = mk(1, 1, 2'b00, 8'h19, 1, 4'hF,  1, 0, 0, 1);
        tbl[17] = mk(1, 1, 2'b11, 8'h00, 1, 4'd0,  1, 0, 0, 0);

        // Reset held with a pending request, then release.
        apply(mk(0, 1, 2'b11, 8'h00, 0, 4'hF, 0, 0, 0, 0));
        apply(mk(0, 1, 2'b11, 8'h00, 0, 4'hF, 0, 0, 0, 0));
        apply(mk(1, 0, 2'b00, 8'h00, 1, 4'hF, 0, 0, 0, 0));

        for (int i = 0; i < N_DEC; i++) apply(tbl[i]);
        apply(mk(1, 0, 2'b00, 8'h00, 1, 4'hF, 0, 0, 0, 0));

        // MULT with a held ADD accepted in the final step cycle.
        apply(mk(1, 1, 2'b00, 8'h18, 1, 4'd9, 0, 1, 0, 0));
        apply(mk(1, 1, 2'b11, 8'h00, 0, 4'd9, 0, 1, 0, 0));
        apply(mk(1, 1, 2'b11, 8'h00, 0, 4'd9, 0, 1, 0, 0));
        apply(mk(1, 1, 2'b11, 8'h00, 0, 4'd9, 1, 1, 1, 0));
        apply(mk(1, 1, 2'b11, 8'h00, 1, 4'd0, 1, 0, 0, 0));
        apply(mk(1, 0, 2'b00, 8'h00, 1, 4'hF, 0, 0, 0, 0));

        // DIV held back-to-back: eight step cycles, last at 4th and 8th.
        for (int k = 0; k < 2; k++) begin
            apply(mk(1, 1, 2'b00, 8'h1A, 1, 4'd10, 0, 1, 0, 0));
            apply(mk(1, 1, 2'b00, 8'h1A, 0, 4'd10, 0, 1, 0, 0));
            apply(mk(1, 1, 2'b00, 8'h1A, 0, 4'd10, 0, 1, 0, 0));
            apply(mk(1, 1, 2'b00, 8'h1A, 0, 4'd10, 1, 1, 1, 0));
        end
        apply(mk(1, 0, 2'b00, 8'h00, 1, 4'hF, 0, 0, 0, 0));

        // Reset during the second DIV step aborts the op.
        apply(mk(1, 1, 2'b00, 8'h1A, 1, 4'd10, 0, 1, 0, 0));
        apply(mk(1, 0, 2'b00, 8'h00, 0, 4'd10, 0, 1, 0, 0));
        apply(mk(0, 0, 2'b00, 8'h00, 0, 4'hF,  0, 0, 0, 0));
        apply(mk(1, 1, 2'b00, 8'h05, 1, 4'd5,  1, 0, 0, 0));
        apply(mk(1, 0, 2'b00, 8'h00, 1, 4'hF,  0, 0, 0, 0));

        @(posedge clk);
        #3;
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
